// File: rtl/gearbox_256_192.sv
// gearbox_256_192: 256-bit to 192-bit receive gearbox over a 64-bit-chunk buffer.
module gearbox_256_192 (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_enable,
  output logic         out_idle,
  input  logic [255:0] in_data,
  input  logic         in_datavalid,
  output logic [191:0] out_data,
  output logic         out_datavalid,
  input  logic         in_idle,
  output logic         overflow_err
);
  logic [63:0] chunk_q [8];
  logic [63:0] chunk_d [8];
  logic [3:0]  cnt_q, cnt_d, wr_base;
  logic        ovf_q, ovf_d, pop, push;
  always_comb begin
    out_idle = !reset && in_enable && cnt_q <= 4'd4;
    pop = !reset && in_enable && in_idle && cnt_q >= 4'd3;
    push = in_datavalid && out_idle;
    out_datavalid = pop;
    out_data = {chunk_q[2], chunk_q[1], chunk_q[0]};
    wr_base = pop ? cnt_q - 4'd3 : cnt_q;
    cnt_d = wr_base + (push ? 4'd4 : 4'd0);
    ovf_d = ovf_q || (in_datavalid && !out_idle);
    chunk_d = chunk_q;
    if (pop) for (int i = 0; i < 5; i++) chunk_d[i] = chunk_q[i + 3];
    // new chunks land just above the survivors of this cycle's pop
    if (push) for (int k = 0; k < 4; k++) chunk_d[3'(wr_base + 4'(k))] = in_data[64*k +: 64];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
      for (int i = 0; i < 8; i++) chunk_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      chunk_q <= chunk_d;
    end
  end
  assign overflow_err = ovf_q;
endmodule

// File: tb/tb_gearbox_256_192.sv
// tb_gearbox_256_192: randomized bench against a chunk-queue reference model.
module tb_gearbox_256_192;
  logic clk = 1'b0;
  logic reset, in_enable, in_datavalid, in_idle;
  logic [255:0] in_data;
  logic out_idle, out_datavalid, overflow_err;
  logic [191:0] out_data;
  logic [63:0] q[$];
  bit ovf_m, e_idle, e_pop;
  logic [191:0] e_word;
  int nchk = 0, npass = 0;

  always #5 clk = ~clk;

  gearbox_256_192 dut (
    .clk(clk), .reset(reset), .in_enable(in_enable), .out_idle(out_idle),
    .in_data(in_data), .in_datavalid(in_datavalid), .out_data(out_data),
    .out_datavalid(out_datavalid), .in_idle(in_idle), .overflow_err(overflow_err)
  );

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // inputs applied just after a rising edge; model predictions for this cycle
  task automatic drive(input bit en, input bit rst, input bit dv, input bit idl, input logic [255:0] d);
    in_enable = en; reset = rst; in_datavalid = dv; in_idle = idl; in_data = d;
    e_idle = !rst && en && q.size() <= 4;
    e_pop = !rst && en && idl && q.size() >= 3;
    e_word = 'x;
    if (q.size() >= 3) e_word = {q[2], q[1], q[0]};
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      q.delete();
      ovf_m = 0;
    end else begin
      if (in_datavalid && !e_idle) ovf_m = 1;
      if (e_pop) repeat (3) void'(q.pop_front());
      if (in_datavalid && e_idle) for (int k = 0; k < 4; k++) q.push_back(in_data[64*k +: 64]);
    end
    #1;
  endtask

  task automatic do_reset();
    drive(1, 1, 0, 0, '0);
    tick();
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      drive(1, 1, 0, 1, rand256());
      nchk++; if (out_idle !== 1'b0) $display("FAIL reset_idle got %b want 0", out_idle); else npass++;
      nchk++; if (out_datavalid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_datavalid); else npass++;
      nchk++; if (out_data !== 192'd0) $display("FAIL reset_data got %h want 0", out_data); else npass++;
      nchk++; if (overflow_err !== 1'b0) $display("FAIL reset_ovf got %b want 0", overflow_err); else npass++;
      tick();
    end
    drive(1, 0, 0, 1, '0);
    nchk++; if (out_idle !== 1'b1) $display("FAIL post_reset_idle got %b want 1", out_idle); else npass++;
    nchk++; if (dut.cnt_q !== 4'd0) $display("FAIL post_reset_cnt got %0d want 0", dut.cnt_q); else npass++;
    tick();
  endtask

  task automatic test_ordering();
    logic [255:0] w [3];
    int wi = 0, k = 0;
    bit dv;
    for (int i = 0; i < 3; i++) for (int j = 0; j < 4; j++) w[i][64*j +: 64] = 64'(4*i + j);
    do_reset();
    for (int c = 0; c < 10; c++) begin
      dv = wi < 3 && q.size() <= 4;
      drive(1, 0, dv, 1, dv ? w[wi] : '0);
      nchk++; if (out_datavalid !== e_pop) $display("FAIL order_valid cyc %0d got %b want %b", c, out_datavalid, e_pop); else npass++;
      if (out_datavalid === 1'b1) begin
        nchk++;
        if (out_data !== {64'(3*k+2), 64'(3*k+1), 64'(3*k)})
          $display("FAIL order_data word %0d got %h want chunks %0d..%0d", k, out_data, 3*k+2, 3*k);
        else npass++;
        k++;
      end
      tick();
      if (dv) wi++;
    end
    nchk++; if (k !== 4) $display("FAIL order_count got %0d want 4", k); else npass++;
  endtask

  task automatic test_throughput();
    int acc = 0, dp = 0, cyc = 0;
    bit dv;
    do_reset();
    while (cyc < 200 && (acc < 30 || q.size() >= 3)) begin
      dv = acc < 30 && q.size() <= 4;
      drive(1, 0, dv, 1, dv ? rand256() : '0);
      nchk++; if (out_idle !== e_idle) $display("FAIL thr_idle cyc %0d got %b want %b", cyc, out_idle, e_idle); else npass++;
      nchk++; if (out_datavalid !== e_pop) $display("FAIL thr_valid cyc %0d got %b want %b", cyc, out_datavalid, e_pop); else npass++;
      if (e_pop) begin
        nchk++; if (out_data !== e_word) $display("FAIL thr_data cyc %0d got %h want %h", cyc, out_data, e_word); else npass++;
      end
      if (out_datavalid === 1'b1) dp++;
      tick();
      if (dv) acc++;
      cyc++;
    end
    nchk++; if (dp !== 40) $display("FAIL thr_words got %0d want 40 (pushes %0d)", dp, acc); else npass++;
    nchk++; if (dut.cnt_q !== 4'd0) $display("FAIL thr_cnt got %0d want 0", dut.cnt_q); else npass++;
  endtask

  task automatic test_back_pressure();
    do_reset();
    for (int c = 0; c < 2; c++) begin
      drive(1, 0, 1, 0, rand256());
      nchk++; if (out_idle !== 1'b1) $display("FAIL bp_accept cyc %0d got %b want 1", c, out_idle); else npass++;
      tick();
    end
    drive(1, 0, 0, 0, '0);
    nchk++; if (dut.cnt_q !== 4'd8) $display("FAIL bp_cnt_full got %0d want 8", dut.cnt_q); else npass++;
    nchk++; if (out_idle !== 1'b0) $display("FAIL bp_idle_full got %b want 0", out_idle); else npass++;
    nchk++; if (out_datavalid !== 1'b0) $display("FAIL bp_hold_valid got %b want 0", out_datavalid); else npass++;
    tick();
    for (int c = 0; c < 2; c++) begin
      drive(1, 0, 0, 1, '0);
      nchk++; if (out_idle !== 1'b0) $display("FAIL bp_drain_idle %0d got %b want 0", c, out_idle); else npass++;
      nchk++; if (out_datavalid !== 1'b1) $display("FAIL bp_drain_valid %0d got %b want 1", c, out_datavalid); else npass++;
      nchk++; if (out_data !== e_word) $display("FAIL bp_drain_data %0d got %h want %h", c, out_data, e_word); else npass++;
      tick();
    end
    for (int c = 0; c < 3; c++) begin
      drive(1, 0, c == 0, 1, c == 0 ? rand256() : '0);
      if (c == 0) begin
        nchk++; if (dut.cnt_q !== 4'd2) $display("FAIL bp_cnt_after got %0d want 2", dut.cnt_q); else npass++;
        nchk++; if (out_idle !== 1'b1) $display("FAIL bp_idle_back got %b want 1", out_idle); else npass++;
      end
      nchk++; if (out_datavalid !== e_pop) $display("FAIL bp_tail_valid %0d got %b want %b", c, out_datavalid, e_pop); else npass++;
      if (e_pop) begin
        nchk++; if (out_data !== e_word) $display("FAIL bp_tail_data %0d got %h want %h", c, out_data, e_word); else npass++;
      end
      tick();
    end
    nchk++; if (dut.cnt_q !== 4'd0) $display("FAIL bp_cnt_end got %0d want 0", dut.cnt_q); else npass++;
  endtask

  task automatic test_protocol_error();
    do_reset();
    for (int c = 0; c < 2; c++) begin
      drive(1, 0, 1, 0, rand256());
      tick();
    end
    drive(1, 0, 1, 0, rand256());
    nchk++; if (out_idle !== 1'b0) $display("FAIL err_idle got %b want 0", out_idle); else npass++;
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(1, 0, 0, 0, '0);
      nchk++; if (overflow_err !== ovf_m) $display("FAIL err_sticky %0d got %b want %b", c, overflow_err, ovf_m); else npass++;
      nchk++; if (dut.cnt_q !== 4'd8) $display("FAIL err_cnt %0d got %0d want 8", c, dut.cnt_q); else npass++;
      tick();
    end
    do_reset();
    drive(1, 0, 0, 0, '0);
    nchk++; if (overflow_err !== 1'b0) $display("FAIL err_clear got %b want 0", overflow_err); else npass++;
    tick();
  endtask

  task automatic test_enable_mid();
    int acc = 0;
    bit dv;
    do_reset();
    for (int c = 0; c < 2; c++) begin
      drive(1, 0, 1, 1, rand256());
      tick();
    end
    for (int c = 0; c < 3; c++) begin
      drive(0, 0, 0, 1, '0);
      nchk++; if (out_datavalid !== 1'b0) $display("FAIL en_valid %0d got %b want 0", c, out_datavalid); else npass++;
      nchk++; if (out_idle !== 1'b0) $display("FAIL en_idle %0d got %b want 0", c, out_idle); else npass++;
      nchk++; if (dut.cnt_q !== 4'd5) $display("FAIL en_cnt %0d got %0d want 5", c, dut.cnt_q); else npass++;
      tick();
    end
    for (int c = 0; c < 20; c++) begin
      dv = acc < 4 && q.size() <= 4;
      drive(1, 0, dv, 1, dv ? rand256() : '0);
      nchk++; if (out_datavalid !== e_pop) $display("FAIL en_resume_valid %0d got %b want %b", c, out_datavalid, e_pop); else npass++;
      if (e_pop) begin
        nchk++; if (out_data !== e_word) $display("FAIL en_resume_data %0d got %h want %h", c, out_data, e_word); else npass++;
      end
      tick();
      if (dv) acc++;
    end
    nchk++; if (dut.cnt_q !== 4'd0) $display("FAIL en_cnt_end got %0d want 0", dut.cnt_q); else npass++;
  endtask

  task automatic test_reset_mid();
    int acc = 0;
    bit dv;
    do_reset();
    for (int c = 0; c < 2; c++) begin
      drive(1, 0, 1, 1, rand256());
      tick();
    end
    do_reset();
    drive(1, 0, 0, 1, '0);
    nchk++; if (dut.cnt_q !== 4'd0) $display("FAIL rst_mid_cnt got %0d want 0", dut.cnt_q); else npass++;
    nchk++; if (out_datavalid !== 1'b0) $display("FAIL rst_mid_valid got %b want 0", out_datavalid); else npass++;
    tick();
    for (int c = 0; c < 10; c++) begin
      dv = acc < 3 && q.size() <= 4;
      drive(1, 0, dv, 1, dv ? rand256() : '0);
      nchk++; if (out_datavalid !== e_pop) $display("FAIL rst_mid_valid %0d got %b want %b", c, out_datavalid, e_pop); else npass++;
      if (e_pop) begin
        nchk++; if (out_data !== e_word) $display("FAIL rst_mid_data %0d got %h want %h", c, out_data, e_word); else npass++;
      end
      tick();
      if (dv) acc++;
    end
  endtask

  initial begin
    reset = 1'b1; in_enable = 1'b1; in_datavalid = 1'b0; in_idle = 1'b0; in_data = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_ordering();
    test_throughput();
    test_back_pressure();
    test_protocol_error();
    test_enable_mid();
    test_reset_mid();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
